// File: rtl/pipe_ctrl.sv
// Frame controller for a 3x3 conv + 2x2 pool datapath: holds the weight bank,
// gates upstream pixels into the pipe, then waits for conv/pool drain or a timeout.
module pipe_ctrl #(
  parameter int IMG_W     = 220,
  parameter int IMG_H     = 220,
  parameter int DRAIN_MAX = 4095
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cfg_we,
  input  logic [3:0]   cfg_addr,
  input  logic [31:0]  cfg_wdata,
  output logic [287:0] w_bus,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         pix_valid,
  input  logic         conv_valid,
  input  logic         pool_valid,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic         cfg_err,
  output logic [15:0]  pix_cnt
);

  localparam int DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX + 1) : 1;

  localparam logic [15:0]   N_PIX_C     = 16'(IMG_W * IMG_H);
  localparam logic [15:0]   N_CONV_C    = 16'((IMG_W - 2) * (IMG_H - 2));
  localparam logic [15:0]   N_POOL_C    = 16'(((IMG_W - 2) / 2) * ((IMG_H - 2) / 2));
  localparam logic [DW-1:0] DRAIN_MAX_C = DW'(DRAIN_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   weights [9];
  logic [15:0]   conv_cnt, pool_cnt;
  logic [15:0]   conv_nxt, pool_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          cfg_ok, cfg_bad, start_ok, last_pix, complete, drain_hit;

  for (genvar k = 0; k < 9; k++) begin : g_wbus
    assign w_bus[32*k +: 32] = weights[k];
  end

  assign in_ready  = (state_q == S_STREAM);
  assign pix_valid = in_valid & in_ready;
  assign busy      = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

  // Weights are frozen outside IDLE so the datapath sees one bank per frame.
  assign cfg_ok   = cfg_we && (state_q == S_IDLE) && (cfg_addr <= 4'd8);
  assign cfg_bad  = cfg_we && !cfg_ok;
  assign start_ok = start && (state_q == S_IDLE);
  assign last_pix = pix_valid && (pix_cnt == N_PIX_C - 16'd1);

  // Completion looks at the counts including this cycle's strobes.
  assign conv_nxt  = (conv_valid && conv_cnt != N_CONV_C) ? conv_cnt + 16'd1 : conv_cnt;
  assign pool_nxt  = (pool_valid && pool_cnt != N_POOL_C) ? pool_cnt + 16'd1 : pool_cnt;
  assign drain_nxt = drain_cnt + 1'b1;
  assign complete  = (conv_nxt == N_CONV_C) && (pool_nxt == N_POOL_C);
  assign drain_hit = (drain_nxt == DRAIN_MAX_C);

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start)                 state_d = S_STREAM;
      S_STREAM: if (last_pix)              state_d = S_DRAIN;
      S_DRAIN:  if (complete || drain_hit) state_d = S_DONE;
      S_DONE:                              state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      pix_cnt   <= '0;
      conv_cnt  <= '0;
      pool_cnt  <= '0;
      drain_cnt <= '0;
      timeout   <= 1'b0;
      cfg_err   <= 1'b0;
      // NOTE: the weight bank is reset too, since w_bus must read zero after reset.
      for (int k = 0; k < 9; k++) weights[k] <= '0;
    end else begin
      state_q <= state_d;

      if (cfg_ok) weights[cfg_addr] <= cfg_wdata;

      if (start_ok) begin
        pix_cnt   <= '0;
        conv_cnt  <= '0;
        pool_cnt  <= '0;
        drain_cnt <= '0;
        timeout   <= 1'b0;
        cfg_err   <= 1'b0;
      end

      // An illegal write in the same cycle as start still flags the error.
      if (cfg_bad) cfg_err <= 1'b1;

      if (pix_valid) pix_cnt <= pix_cnt + 16'd1;

      if (busy) begin
        conv_cnt <= conv_nxt;
        pool_cnt <= pool_nxt;
      end

      if (state_q == S_DRAIN) begin
        drain_cnt <= drain_nxt;
        if (!complete && drain_hit) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl on a 6x6 frame: config vector table,
// randomized frames against a frame-level reference model, and reset/timeout corners.
module tb_pipe_ctrl;

  localparam int W      = 6;
  localparam int H      = 6;
  localparam int DMAX   = 10;
  localparam int N_PIX  = W * H;
  localparam int N_CONV = (W - 2) * (H - 2);
  localparam int N_POOL = ((W - 2) / 2) * ((H - 2) / 2);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic [287:0] w_bus;
  logic         in_valid;
  logic         in_ready;
  logic         pix_valid;
  logic         conv_valid;
  logic         pool_valid;
  logic         busy;
  logic         done;
  logic         timeout;
  logic         cfg_err;
  logic [15:0]  pix_cnt;

  pipe_ctrl #(.IMG_W(W), .IMG_H(H), .DRAIN_MAX(DMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .w_bus      (w_bus),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pix_valid  (pix_valid),
    .conv_valid (conv_valid),
    .pool_valid (pool_valid),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cfg_err    (cfg_err),
    .pix_cnt    (pix_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the weight bank and the sticky error flag as the bench expects them.
  logic [31:0] wm [9];
  bit          err_m;

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [31:0] data;
    int          chk_addr;
    logic [31:0] exp_word;
    bit          exp_err;
  } cfg_vec_t;

  cfg_vec_t vecs [6];

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [287:0] model_bus();
    logic [287:0] b;
    for (int k = 0; k < 9; k++) b[32*k +: 32] = wm[k];
    return b;
  endfunction

  task automatic idle_inputs();
    start      = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
    in_valid   = 1'b0;
    conv_valid = 1'b0;
    pool_valid = 1'b0;
  endtask

  // One full frame. Any cfg_we already on the pins is held through the start edge.
  task automatic run_frame(input string tag, input int valid_pct, input int strobe_pct,
                           input int conv_total, input int pool_total, input bit bad_cfg);
    int acc, conv_m, pool_m, cl, pl, cyc, dc;
    bit ended, exp_to;

    if (cfg_we && cfg_addr <= 4'd8) wm[cfg_addr] = cfg_wdata;
    start = 1'b1;
    tick();
    idle_inputs();
    err_m = 1'b0;
    check({tag, " start busy"}, busy, 1'b1);
    check({tag, " start pix_cnt"}, pix_cnt, 16'd0);
    check({tag, " start timeout"}, timeout, 1'b0);
    check({tag, " start cfg_err"}, cfg_err, 1'b0);
    check({tag, " start w_bus"}, w_bus, model_bus());

    acc = 0; conv_m = 0; pool_m = 0; cl = conv_total; pl = pool_total; cyc = 0;
    while (acc < N_PIX) begin
      if (cyc >= 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s stream budget: got %0d pixels, expected %0d", tag, acc, N_PIX);
        break;
      end
      in_valid   = ($urandom_range(99) < valid_pct);
      conv_valid = (cl > 0) && ($urandom_range(99) < strobe_pct);
      pool_valid = (pl > 0) && ($urandom_range(99) < strobe_pct);
      cfg_we     = bad_cfg && ($urandom_range(7) == 0);
      cfg_addr   = 4'($urandom_range(15));
      cfg_wdata  = $urandom;
      if (cfg_we) err_m = 1'b1;
      #1;
      check({tag, " stream in_ready"}, in_ready, 1'b1);
      check({tag, " stream pix_valid"}, pix_valid, in_valid);
      tick();
      if (in_valid) acc++;
      if (conv_valid) begin cl--; if (conv_m < N_CONV) conv_m++; end
      if (pool_valid) begin pl--; if (pool_m < N_POOL) pool_m++; end
      cyc++;
      check({tag, " stream pix_cnt"}, pix_cnt, 16'(acc));
    end
    idle_inputs();

    check({tag, " drain entry in_ready"}, in_ready, 1'b0);
    check({tag, " drain entry busy"}, busy, 1'b1);

    // Drain ends when both saturating counts are full, else after DMAX cycles.
    dc = 0; ended = 1'b0; exp_to = 1'b0;
    while (!ended) begin
      in_valid   = 1'($urandom_range(1));
      conv_valid = (cl > 0) && ($urandom_range(1) == 1);
      pool_valid = (pl > 0) && ($urandom_range(1) == 1);
      #1;
      check({tag, " drain in_ready"}, in_ready, 1'b0);
      check({tag, " drain pix_valid"}, pix_valid, 1'b0);
      check({tag, " drain done"}, done, 1'b0);
      tick();
      dc++;
      if (conv_valid) begin cl--; if (conv_m < N_CONV) conv_m++; end
      if (pool_valid) begin pl--; if (pool_m < N_POOL) pool_m++; end
      if (conv_m == N_CONV && pool_m == N_POOL) begin
        ended = 1'b1; exp_to = 1'b0;
      end else if (dc == DMAX) begin
        ended = 1'b1; exp_to = 1'b1;
      end
    end
    idle_inputs();

    check({tag, " done pulse"}, done, 1'b1);
    check({tag, " done busy"}, busy, 1'b0);
    check({tag, " done timeout"}, timeout, exp_to);
    check({tag, " done pix_cnt"}, pix_cnt, 16'(N_PIX));
    check({tag, " done cfg_err"}, cfg_err, err_m);
    check({tag, " done w_bus"}, w_bus, model_bus());
    tick();
    check({tag, " idle done"}, done, 1'b0);
    check({tag, " idle busy"}, busy, 1'b0);
    check({tag, " idle timeout hold"}, timeout, exp_to);
    check({tag, " idle pix_cnt hold"}, pix_cnt, 16'(N_PIX));
  endtask

  initial begin
    vecs[0] = '{we: 1'b1, addr: 4'd4,  data: 32'h4080_0000, chk_addr: 4, exp_word: 32'h4080_0000, exp_err: 1'b0};
    vecs[1] = '{we: 1'b1, addr: 4'd1,  data: 32'hbf80_0000, chk_addr: 1, exp_word: 32'hbf80_0000, exp_err: 1'b0};
    vecs[2] = '{we: 1'b1, addr: 4'd9,  data: 32'hdead_beef, chk_addr: 4, exp_word: 32'h4080_0000, exp_err: 1'b1};
    vecs[3] = '{we: 1'b0, addr: 4'd2,  data: 32'h1234_5678, chk_addr: 2, exp_word: 32'h0000_0000, exp_err: 1'b1};
    vecs[4] = '{we: 1'b1, addr: 4'd15, data: 32'hcafe_f00d, chk_addr: 1, exp_word: 32'hbf80_0000, exp_err: 1'b1};
    vecs[5] = '{we: 1'b1, addr: 4'd8,  data: 32'h3f00_0000, chk_addr: 8, exp_word: 32'h3f00_0000, exp_err: 1'b1};

    for (int k = 0; k < 9; k++) wm[k] = '0;
    err_m = 1'b0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("reset w_bus", w_bus, '0);
    check("reset pix_cnt", pix_cnt, 16'd0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset timeout", timeout, 1'b0);
    check("reset cfg_err", cfg_err, 1'b0);
    check("reset in_ready", in_ready, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cfg_we    = vecs[i].we;
      cfg_addr  = vecs[i].addr;
      cfg_wdata = vecs[i].data;
      if (vecs[i].we && vecs[i].addr <= 4'd8) wm[vecs[i].addr] = vecs[i].data;
      tick();
      cfg_we = 1'b0;
      check($sformatf("cfg vec%0d word", i), w_bus[32*vecs[i].chk_addr +: 32], vecs[i].exp_word);
      check($sformatf("cfg vec%0d cfg_err", i), cfg_err, vecs[i].exp_err);
      check($sformatf("cfg vec%0d w_bus", i), w_bus, model_bus());
      if (i == 1) begin
        check("cfg two-weight bus", w_bus,
              {128'd0, 32'h4080_0000, 64'd0, 32'hbf80_0000, 32'd0});
      end
    end

    // Start coinciding with a legal write: the frame must see the new weight.
    cfg_we    = 1'b1;
    cfg_addr  = 4'd0;
    cfg_wdata = 32'h3f80_0000;
    run_frame("normal", 100, 100, N_CONV, N_POOL, 1'b0);
    check("coincident write w0", w_bus[31:0], 32'h3f80_0000);

    run_frame("timeout", 100, 100, N_CONV, 3, 1'b0);
    run_frame("after_timeout", 100, 100, N_CONV, N_POOL, 1'b0);
    run_frame("backpressure", 50, 30, N_CONV, N_POOL, 1'b1);
    run_frame("saturate", 60, 100, N_CONV + 6, N_POOL + 3, 1'b0);
    for (int r = 0; r < 3; r++) begin
      run_frame($sformatf("rand%0d", r), 30 + $urandom_range(60), 20 + $urandom_range(70),
                N_CONV - 2 + $urandom_range(6), N_POOL - 1 + $urandom_range(3), 1'($urandom_range(1)));
    end

    // Reset in the middle of a frame: back to IDLE, bank cleared, no done afterwards.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < 20; p++) begin
      in_valid = 1'b1;
      tick();
    end
    check("midreset pix_cnt before", pix_cnt, 16'd20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < 9; k++) wm[k] = '0;
    check("midreset busy", busy, 1'b0);
    check("midreset pix_cnt", pix_cnt, 16'd0);
    check("midreset w_bus", w_bus, model_bus());
    check("midreset in_ready", in_ready, 1'b0);
    check("midreset done", done, 1'b0);
    for (int c = 0; c < 5; c++) begin
      conv_valid = 1'b1;
      pool_valid = 1'b1;
      tick();
      check($sformatf("midreset no done %0d", c), done, 1'b0);
      check($sformatf("midreset idle busy %0d", c), busy, 1'b0);
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
